// File: rtl/spm_control_unit_if.sv
// Signal bundle between the RISC SPM control unit and its processing unit.
// master = control unit (drives loads/selects), slave = processing unit.
interface spm_control_unit_if #(
  parameter int word_size = 8,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
);
  logic [word_size-1:0] instruction;
  logic                 Zflag;
  logic                 Load_R0;
  logic                 Load_R1;
  logic                 Load_R2;
  logic                 Load_R3;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic [Sel1_size-1:0] Sel_Bus_1_Mux;
  logic [Sel2_size-1:0] Sel_Bus_2_Mux;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic                 write;
  logic                 halt;

  modport master (
    input  instruction, Zflag,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, write, halt
  );

  modport slave (
    output instruction, Zflag,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, write, halt
  );
endinterface

// File: rtl/spm_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit RISC SPM; Mealy outputs from state,
// opcode, src, dest and Zflag.
//
// state   | meaning
// S_idle  | just out of reset, no action
// S_fet1  | PC -> Add_R
// S_fet2  | mem -> IR, PC++
// S_dec   | decode; ALU ops load Y, NOT completes, memory/branch ops fetch operand address
// S_ex1   | ALU result -> R[dest] and Z
// S_rd1   | operand word -> Add_R, PC++
// S_rd2   | mem -> R[dest]
// S_wr1   | operand word -> Add_R, PC++
// S_wr2   | R[src] -> mem
// S_br1   | operand word -> Add_R
// S_br2   | mem -> PC
// S_halt  | stopped until reset
module spm_control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2,
  parameter int state_size = 4
) (
  input  logic                clk,
  input  logic                rst,
  spm_control_unit_if.master  bus
);
  typedef enum logic [state_size-1:0] {
    S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2,
    S_wr1, S_wr2, S_br1, S_br2, S_halt
  } state_t;

  localparam logic [op_size-1:0] OP_NOP = op_size'(0);
  localparam logic [op_size-1:0] OP_ADD = op_size'(1);
  localparam logic [op_size-1:0] OP_SUB = op_size'(2);
  localparam logic [op_size-1:0] OP_AND = op_size'(3);
  localparam logic [op_size-1:0] OP_NOT = op_size'(4);
  localparam logic [op_size-1:0] OP_RD  = op_size'(5);
  localparam logic [op_size-1:0] OP_WR  = op_size'(6);
  localparam logic [op_size-1:0] OP_BR  = op_size'(7);
  localparam logic [op_size-1:0] OP_BRZ = op_size'(8);

  localparam logic [Sel1_size-1:0] SEL1_PC   = Sel1_size'(4);
  localparam logic [Sel2_size-1:0] SEL2_ALU  = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] SEL2_BUS1 = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] SEL2_MEM  = Sel2_size'(2);

  state_t state_q, state_d;

  logic [op_size-1:0]   opcode;
  logic [1:0]           src, dest;
  logic [3:0]           load_r;
  logic                 load_pc, inc_pc, load_ir, load_add_r;
  logic                 load_reg_y, load_reg_z, write_en, halt_o;
  logic [Sel1_size-1:0] sel1;
  logic [Sel2_size-1:0] sel2;

  assign opcode = bus.instruction[word_size-1 -: op_size];
  assign src    = bus.instruction[3:2];
  assign dest   = bus.instruction[1:0];

  always_comb begin
    state_d    = state_q;
    load_r     = '0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write_en   = 1'b0;
    halt_o     = 1'b0;
    sel1       = '0;
    sel2       = '0;
    case (state_q)
      S_idle: state_d = S_fet1;
      S_fet1: begin
        sel1 = SEL1_PC; sel2 = SEL2_BUS1; load_add_r = 1'b1;
        state_d = S_fet2;
      end
      S_fet2: begin
        sel2 = SEL2_MEM; load_ir = 1'b1; inc_pc = 1'b1;
        state_d = S_dec;
      end
      S_dec: begin
        case (opcode)
          OP_NOP: state_d = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel1 = Sel1_size'(src); sel2 = SEL2_BUS1; load_reg_y = 1'b1;
            state_d = S_ex1;
          end
          OP_NOT: begin
            sel1 = Sel1_size'(src); sel2 = SEL2_ALU;
            load_r[dest] = 1'b1; load_reg_z = 1'b1;
            state_d = S_fet1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel1 = SEL1_PC; sel2 = SEL2_BUS1; load_add_r = 1'b1;
            state_d = (opcode == OP_RD) ? S_rd1 : (opcode == OP_WR) ? S_wr1 : S_br1;
          end
          OP_BRZ: begin
            if (bus.Zflag) begin
              sel1 = SEL1_PC; sel2 = SEL2_BUS1; load_add_r = 1'b1;
              state_d = S_br1;
            end else begin
              // not taken: step PC over the operand word
              inc_pc  = 1'b1;
              state_d = S_fet1;
            end
          end
          default: state_d = S_halt;
        endcase
      end
      S_ex1: begin
        sel1 = Sel1_size'(dest); sel2 = SEL2_ALU;
        load_r[dest] = 1'b1; load_reg_z = 1'b1;
        state_d = S_fet1;
      end
      S_rd1, S_wr1: begin
        sel2 = SEL2_MEM; load_add_r = 1'b1; inc_pc = 1'b1;
        state_d = (state_q == S_rd1) ? S_rd2 : S_wr2;
      end
      S_rd2: begin
        sel2 = SEL2_MEM; load_r[dest] = 1'b1;
        state_d = S_fet1;
      end
      S_wr2: begin
        sel1 = Sel1_size'(src); write_en = 1'b1;
        state_d = S_fet1;
      end
      S_br1: begin
        sel2 = SEL2_MEM; load_add_r = 1'b1;
        state_d = S_br2;
      end
      S_br2: begin
        sel2 = SEL2_MEM; load_pc = 1'b1;
        state_d = S_fet1;
      end
      S_halt: begin
        halt_o  = 1'b1;
        state_d = S_halt;
      end
      default: state_d = S_halt;
    endcase

    // reset masks every strobe in the same cycle so an aborted instruction loads nothing
    if (!rst) begin
      load_r     = '0;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      load_ir    = 1'b0;
      load_add_r = 1'b0;
      load_reg_y = 1'b0;
      load_reg_z = 1'b0;
      write_en   = 1'b0;
      halt_o     = 1'b0;
      sel1       = '0;
      sel2       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_idle;
    else      state_q <= state_d;
  end

  assign bus.Load_R0       = load_r[0];
  assign bus.Load_R1       = load_r[1];
  assign bus.Load_R2       = load_r[2];
  assign bus.Load_R3       = load_r[3];
  assign bus.Load_PC       = load_pc;
  assign bus.Inc_PC        = inc_pc;
  assign bus.Sel_Bus_1_Mux = sel1;
  assign bus.Sel_Bus_2_Mux = sel2;
  assign bus.Load_IR       = load_ir;
  assign bus.Load_Add_R    = load_add_r;
  assign bus.Load_Reg_Y    = load_reg_y;
  assign bus.Load_Reg_Z    = load_reg_z;
  assign bus.write         = write_en;
  assign bus.halt          = halt_o;
endmodule
